operand_loader: RTL and testbench

//  Upstream operand collector for the (A/B)*(C+D)*(E-F) arithmetic stage.
//  - Receives a byte stream over valid/ready and assembles 6-byte frames in order A,B,C,D,E,F.
//  - Presents each complete frame as registered, stable operands A..F under an ops_valid/ops_ready handshake.
//  - Flags divide-by-zero (B==0) alongside the frame and discards stalled partial frames after a timeout.
//  - Double-buffered: the next frame is collected while the current one is held for the consumer.

---
 rtl/operand_loader.sv | 130 +++++++++++++
 tb/tb_operand_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Collects a byte stream into six-operand frames (A..F) and presents each
// complete frame on a registered, double-buffered ops_valid/ops_ready slot.
module operand_loader #(
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] C,
   output logic [DATA_W-1:0] D,
   output logic [DATA_W-1:0] E,
   output logic [DATA_W-1:0] F,
   output logic              ops_valid,
   input  logic              ops_ready,
   output logic              div_zero,
   output logic              frame_err
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_e;

   state_e            state_q;
   logic [2:0]        idx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] shadow_q [5];
   logic [DATA_W-1:0] ops_q    [6];
   logic              ops_valid_q;
   logic              div_zero_q;
   logic              frame_err_q;

   logic in_ready_s;
   logic accept_s;
   logic complete_s;
   logic handshake_s;

   // The last byte slot is blocked only while the presented frame is still unread.
   assign in_ready_s  = !((idx_q == 3'd5) && ops_valid_q);
   assign accept_s    = in_valid & in_ready_s;
   assign complete_s  = accept_s && (state_q == ST_COLLECT) && (idx_q == 3'd5);
   assign handshake_s = ops_valid_q & ops_ready;

   // Byte collection FSM, timeout watchdog and output slot.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= 3'd0;
         cnt_q       <= '0;
         ops_valid_q <= 1'b0;
         div_zero_q  <= 1'b0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < 5; i++) shadow_q[i] <= '0;
         for (int i = 0; i < 6; i++) ops_q[i] <= '0;
      end else begin
         frame_err_q <= 1'b0;

         // Byte 5 bypasses the shadow so the frame is presented one cycle after it arrives.
         if (complete_s) begin
            for (int i = 0; i < 5; i++) ops_q[i] <= shadow_q[i];
            ops_q[5]    <= in_data;
            div_zero_q  <= (shadow_q[1] == '0);
            ops_valid_q <= 1'b1;
         end else if (handshake_s) begin
            ops_valid_q <= 1'b0;
         end else begin
            ops_valid_q <= ops_valid_q;
         end

         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (accept_s) begin
                  shadow_q[0] <= in_data;
                  idx_q       <= 3'd1;
                  state_q     <= ST_COLLECT;
               end else begin
                  idx_q <= 3'd0;
               end
            end
            ST_COLLECT: begin
               if (accept_s) begin
                  cnt_q <= '0;
                  if (idx_q == 3'd5) begin
                     idx_q   <= 3'd0;
                     state_q <= ST_IDLE;
                  end else begin
                     shadow_q[idx_q] <= in_data;
                     idx_q           <= idx_q + 3'd1;
                  end
               end else if (!in_ready_s) begin
                  cnt_q <= cnt_q;
               end else if (cnt_q == CNT_LAST) begin
                  frame_err_q <= 1'b1;
                  idx_q       <= 3'd0;
                  cnt_q       <= '0;
                  state_q     <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               idx_q   <= 3'd0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign A         = ops_q[0];
   assign B         = ops_q[1];
   assign C         = ops_q[2];
   assign D         = ops_q[3];
   assign E         = ops_q[4];
   assign F         = ops_q[5];
   assign ops_valid = ops_valid_q;
   assign div_zero  = div_zero_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed and randomized bench for operand_loader, checked against a
// frame-level reference model (byte queue plus presented-frame slot).
module tb_operand_loader;

   localparam int TO = 16;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A, B, C, D, E, F;
   logic       ops_valid;
   logic       ops_ready;
   logic       div_zero;
   logic       frame_err;

   operand_loader #(.DATA_W(8), .TIMEOUT_CYC(TO)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .E         (E),
      .F         (F),
      .ops_valid (ops_valid),
      .ops_ready (ops_ready),
      .div_zero  (div_zero),
      .frame_err (frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   int tests = 0;
   int fails = 0;

   // Reference model: bytes of the frame in progress, and the presented frame.
   logic [7:0] part [$];
   logic [7:0] pres [6];
   bit         pres_valid;
   bit         div_exp;
   bit         err_exp;
   int         idle;
   int         seen;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      part.delete();
      for (int i = 0; i < 6; i++) pres[i] = 8'h00;
      pres_valid = 1'b0;
      div_exp    = 1'b0;
      err_exp    = 1'b0;
      idle       = 0;
   endtask

   function automatic bit exp_ready();
      return !(part.size() == 5 && pres_valid);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_in_ready"}, {7'd0, in_ready}, {7'd0, exp_ready()});
      chk({tag, "_ops_valid"}, {7'd0, ops_valid}, {7'd0, pres_valid});
      chk({tag, "_frame_err"}, {7'd0, frame_err}, {7'd0, err_exp});
      chk({tag, "_div_zero"}, {7'd0, div_zero}, {7'd0, div_exp});
      chk({tag, "_A"}, A, pres[0]);
      chk({tag, "_B"}, B, pres[1]);
      chk({tag, "_C"}, C, pres[2]);
      chk({tag, "_D"}, D, pres[3]);
      chk({tag, "_E"}, E, pres[4]);
      chk({tag, "_F"}, F, pres[5]);
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_edge();
      bit rdy, acc;
      rdy     = exp_ready();
      acc     = in_valid && rdy;
      err_exp = 1'b0;
      if (acc && part.size() == 5) begin
         for (int i = 0; i < 5; i++) pres[i] = part[i];
         pres[5]    = in_data;
         div_exp    = (part[1] == 8'h00);
         pres_valid = 1'b1;
         part.delete();
         idle = 0;
      end else begin
         if (pres_valid && ops_ready) pres_valid = 1'b0;
         if (acc) begin
            part.push_back(in_data);
            idle = 0;
         end else if (part.size() == 0) begin
            idle = 0;
         end else if (rdy) begin
            if (idle == TO - 1) begin
               err_exp = 1'b1;
               part.delete();
               idle = 0;
            end else begin
               idle++;
            end
         end
      end
   endtask

   task automatic cyc(input bit v, input logic [7:0] d, input bit r, input string tag);
      in_valid  = v;
      in_data   = d;
      ops_ready = r;
      check_all(tag);
      if (ops_valid && ops_ready) seen++;
      model_edge();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_frame(input logic [47:0] f, input bit r, input string tag);
      for (int i = 0; i < 6; i++) cyc(1'b1, f[47-8*i -: 8], r, tag);
   endtask

   initial begin
      logic [47:0] f1, f2;
      sys_rst_n = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      ops_ready = 1'b0;
      seen      = 0;
      model_reset();
      #12;
      check_all("reset");
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;

      // Basic frame, consumer always ready.
      send_frame(48'h10_04_03_05_09_02, 1'b1, "t1");
      chk("t1_valid", {7'd0, ops_valid}, 8'h01);
      chk("t1_A", A, 8'h10);
      chk("t1_B", B, 8'h04);
      chk("t1_F", F, 8'h02);
      chk("t1_dz", {7'd0, div_zero}, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, "t1_drain");

      // Backpressure: second frame stalls at its last byte until the slot is read.
      f1 = 48'hA1_A2_A3_A4_A5_A6;
      f2 = 48'hB1_B2_B3_B4_B5_B6;
      send_frame(f1, 1'b0, "t2_f1");
      for (int i = 0; i < 5; i++) cyc(1'b1, f2[47-8*i -: 8], 1'b0, "t2_f2");
      chk("t2_stall", {7'd0, in_ready}, 8'h00);
      cyc(1'b1, 8'hB6, 1'b0, "t2_hold");
      cyc(1'b1, 8'hB6, 1'b0, "t2_hold");
      chk("t2_A_f1", A, 8'hA1);
      cyc(1'b1, 8'hB6, 1'b1, "t2_pulse");
      cyc(1'b1, 8'hB6, 1'b0, "t2_accept");
      chk("t2_A_f2", A, 8'hB1);
      chk("t2_F_f2", F, 8'hB6);

      // Divide-by-zero frame.
      cyc(1'b0, 8'h00, 1'b1, "t3_drain");
      send_frame(48'h40_00_01_01_01_01, 1'b1, "t3");
      chk("t3_A", A, 8'h40);
      chk("t3_B", B, 8'h00);
      chk("t3_dz", {7'd0, div_zero}, 8'h01);

      // Timeout of a partial frame.
      cyc(1'b0, 8'h00, 1'b1, "t4_drain");
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b1, "t4_part");
      for (int i = 0; i < TO; i++) cyc(1'b0, 8'h00, 1'b1, "t4_idle");
      chk("t4_err", {7'd0, frame_err}, 8'h01);
      chk("t4_A_held", A, 8'h40);
      cyc(1'b0, 8'h00, 1'b1, "t4_after");
      chk("t4_err_pulse", {7'd0, frame_err}, 8'h00);
      send_frame(48'h21_22_23_24_25_26, 1'b1, "t4_fresh");
      chk("t4_fresh_A", A, 8'h21);
      chk("t4_fresh_F", F, 8'h26);

      // Asynchronous reset mid-frame.
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0, "t5_part");
      in_valid = 1'b0;
      #2 sys_rst_n = 1'b0;
      #1;
      model_reset();
      chk("t5_A", A, 8'h00);
      chk("t5_valid", {7'd0, ops_valid}, 8'h00);
      check_all("t5_rst");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      send_frame(48'h61_62_63_64_65_66, 1'b1, "t5_after");
      chk("t5_after_A", A, 8'h61);
      chk("t5_after_E", E, 8'h65);

      // Back-to-back frames with the consumer always ready: each presented once.
      cyc(1'b0, 8'h00, 1'b1, "t6_drain");
      seen = 0;
      send_frame(48'h01_02_03_04_05_06, 1'b1, "t6");
      send_frame(48'h11_12_13_14_15_16, 1'b1, "t6");
      send_frame(48'h21_22_23_24_25_26, 1'b1, "t6");
      cyc(1'b0, 8'h00, 1'b1, "t6_tail");
      chk("t6_frames", 8'(seen), 8'd3);

      // Randomized traffic with occasional long gaps.
      for (int n = 0; n < 700; n++) begin
         logic [7:0] d;
         d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            for (int k = 0; k < TO + 2; k++) cyc(1'b0, 8'h00, 1'($urandom_range(0, 1)), "rnd_gap");
         end else begin
            cyc(($urandom_range(0, 9) < 7), d, 1'($urandom_range(0, 1)), "rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
